// File: rtl/nibble_serial_addsub_pkg.sv
// addsub_pkg: shared constants and FSM state type for the nibble-serial
// add/subtract sequencer.
//   NIBBLE_W : width of the shared adder slice
//   OP_ADD   : op_sub encoding for A+B
//   OP_SUB   : op_sub encoding for A-B
//   state_t  : IDLE / RUN / DONE sequencer states
package addsub_pkg;

    localparam int   NIBBLE_W = 4;
    localparam logic OP_ADD   = 1'b0;
    localparam logic OP_SUB   = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_add4.sv
// nibble_add4: purely combinational 4-bit adder slice with carry in/out.
//   a, b : 4-bit addends
//   cin  : carry in
//   sum  : 4-bit sum
//   cout : carry out
module nibble_add4
    import addsub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};

endmodule

// File: rtl/nibble_serial_addsub.sv
// nibble_serial_addsub: multi-precision add/subtract sequencer. Operands of
// NIBBLES*4 bits are walked through one shared 4-bit adder, least significant
// nibble first, one nibble per clock, with carry/borrow rippled between cycles.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (ready only while idle)
//   op_sub              : 0 = A+B, 1 = A-B
//   a, b                : unsigned operands
//   out_valid/out_ready : result handshake
//   result              : sum / difference (held until next op overwrites it)
//   carry               : add carry-out, or sub borrow (A < B)
//   zero                : result == 0
// Optional build macro ADDSUB_SAT_EN: clamp the result on overflow/underflow
// (add -> all ones, sub -> zero) at the RUN->DONE transition.
module nibble_serial_addsub
    import addsub_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         op_sub,
    input  logic [NIBBLES*NIBBLE_W-1:0]  a,
    input  logic [NIBBLES*NIBBLE_W-1:0]  b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NIBBLES*NIBBLE_W-1:0]  result,
    output logic                         carry,
    output logic                         zero
);

    localparam int W     = NIBBLES * NIBBLE_W;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t             state, state_nx;
    logic [W-1:0]       a_q, b_q;       // b_q already inverted for subtract
    logic               op_q;
    logic               cin_q;
    logic [IDX_W-1:0]   idx_q;
    logic               zacc_q;         // running AND of per-nibble zero
    logic [W-1:0]       result_q;
    logic               carry_q;
    logic               zero_q;

    logic [NIBBLE_W-1:0] nib_a, nib_b, nib_sum;
    logic                nib_cout;
    logic                nib_zero;
    logic                last;
    logic                raw_carry;

    // Select the current nibble of each operand.
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib_a = a_q[i*NIBBLE_W +: NIBBLE_W];
                nib_b = b_q[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    nibble_add4 u_add (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (cin_q),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    assign nib_zero  = (nib_sum == '0);
    assign last      = (state == RUN) && (idx_q == IDX_W'(NIBBLES - 1));
    // Subtract is A + ~B + 1, so a missing carry-out means a borrow.
    assign raw_carry = (op_q == OP_SUB) ? ~nib_cout : nib_cout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)  state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_ADD;
            cin_q    <= 1'b0;
            idx_q    <= '0;
            zacc_q   <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q    <= a;
                        b_q    <= (op_sub == OP_SUB) ? ~b : b;
                        op_q   <= op_sub;
                        cin_q  <= op_sub;
                        idx_q  <= '0;
                        zacc_q <= 1'b1;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (idx_q == IDX_W'(i))
                            result_q[i*NIBBLE_W +: NIBBLE_W] <= nib_sum;
                    end
                    cin_q  <= nib_cout;
                    idx_q  <= idx_q + 1'b1;
                    zacc_q <= zacc_q & nib_zero;
                    if (last) begin
                        carry_q <= raw_carry;
                        zero_q  <= zacc_q & nib_zero;
`ifdef ADDSUB_SAT_EN
                        // Clamp overrides the nibble write above; carry
                        // still reports the raw carry/borrow.
                        if (raw_carry) begin
                            result_q <= (op_q == OP_ADD) ? {W{1'b1}} : {W{1'b0}};
                            zero_q   <= (op_q == OP_SUB);
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign result    = result_q;
    assign carry     = carry_q;
    assign zero      = zero_q;

endmodule
